// File: rtl/cam_stream_gen.sv
// -----------------------------------------------------------------------------
// cam_stream_gen
//   Camera-side stream generator. Reads an RGB332 frame buffer and replays it
//   as an OV7670-style pixel bus (vsync / href / px_data), two RGB565 bytes per
//   pixel. Used to feed the capture block in loopback and self-test builds.
//
// Ports
//   pclk         in   pixel clock, all logic on the rising edge
//   rst          in   synchronous reset, active low
//   start        in   rising edge requests one frame (accepted only when idle)
//   busy         out  high while a frame is being generated
//   done         out  set when a frame completes, cleared by the next start
//   mem_rd_addr  out  frame-buffer read address
//   mem_rd_en    out  read strobe, one cycle per address
//   mem_rd_data  in   RGB332 pixel, valid one cycle after the strobe
//   vsync        out  frame sync
//   href         out  line valid
//   px_data      out  pixel byte (0 whenever href is low)
//
// Build option
//   CAM_STREAM_REPLICATE_EN : fill the RGB565 low bits by MSB replication
//                             instead of zeros.
//
// Parameter constraints: H_ACTIVE >= 2, V_BACK >= 3, H_BLANK >= 3,
// H_ACTIVE*V_ACTIVE <= 2**AW.
// -----------------------------------------------------------------------------
module cam_stream_gen #(
   parameter int AW        = 15,
   parameter int H_ACTIVE  = 160,
   parameter int V_ACTIVE  = 120,
   parameter int H_BLANK   = 16,
   parameter int VS_CYCLES = 8,
   parameter int V_BACK    = 16,
   parameter int V_FRONT   = 16
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_rd_addr,
   output logic          mem_rd_en,
   input  logic [7:0]    mem_rd_data,
   output logic          vsync,
   output logic          href,
   output logic [7:0]    px_data
);

   localparam int LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BW   = $clog2(2 * H_ACTIVE);
   localparam int M1   = (VS_CYCLES > V_BACK) ? VS_CYCLES : V_BACK;
   localparam int M2   = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
   localparam int CMAX = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      IDLE, VS_PRE, VBACK, LINE, HBLANK, VFRONT, VS_POST
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;        // timer for sync / blanking states
   logic [BW-1:0]   bc_q, bc_d;          // byte counter within a line
   logic [LW-1:0]   line_q, line_d;
   logic [AW-1:0]   addr_q, addr_d;      // next address to read
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            rd_en_q, rd_en_d;
   logic            dvld_q, dvld_d;      // mem_rd_data valid this cycle
   logic [7:0]      b1_q, b1_d;          // second byte of the pixel in flight
   logic            start_q;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            vsync_q, vsync_d;
   logic            href_q, href_d;
   logic [7:0]      px_q, px_d;

   logic            pre_line;
   logic [CW-1:0]   blank_last;

   // RGB332 -> RGB565 byte expansion
   function automatic logic [7:0] exp_byte0(input logic [7:0] p);
`ifdef CAM_STREAM_REPLICATE_EN
      return {p[7:5], p[7:6], p[4:2]};
`else
      return {p[7:5], 2'b00, p[4:2]};
`endif
   endfunction

   function automatic logic [7:0] exp_byte1(input logic [7:0] p);
`ifdef CAM_STREAM_REPLICATE_EN
      return {p[4:2], p[1:0], p[1:0], p[1]};
`else
      return {3'b000, p[1:0], 3'b000};
`endif
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bc_d      = bc_q;
      line_d    = line_q;
      addr_d    = addr_q;
      rd_addr_d = rd_addr_q;
      rd_en_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = done_q;

      case (state_q)
         IDLE: begin
            if (start && !start_q) begin
               state_d = VS_PRE;
               cnt_d   = '0;
               bc_d    = '0;
               line_d  = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         VS_PRE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(VS_CYCLES - 1)) begin
               state_d = VBACK;
               cnt_d   = '0;
            end
         end
         VBACK: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(V_BACK - 1)) begin
               state_d = LINE;
               bc_d    = '0;
            end
         end
         LINE: begin
            bc_d = bc_q + 1'b1;
            if (bc_q == BW'(2 * H_ACTIVE - 1)) begin
               cnt_d = '0;
               if (line_q == LW'(V_ACTIVE - 1)) begin
                  state_d = VFRONT;
               end else begin
                  state_d = HBLANK;
                  line_d  = line_q + 1'b1;
               end
            end
         end
         HBLANK: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(H_BLANK - 1)) begin
               state_d = LINE;
               bc_d    = '0;
            end
         end
         VFRONT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(V_FRONT - 1)) begin
               state_d = VS_POST;
               cnt_d   = '0;
            end
         end
         VS_POST: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(VS_CYCLES - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Read schedule. A strobe registered here is seen by memory one cycle
      // later and its data is turned into byte0 one cycle after that, so the
      // strobe must lead byte0 by two cycles. Pixels 0 and 1 of a line are
      // therefore requested from the blanking interval (third-last and last
      // cycle), the rest on odd byte slots of the line itself.
      pre_line   = (state_q == VBACK) || (state_q == HBLANK);
      blank_last = (state_q == VBACK) ? CW'(V_BACK - 1) : CW'(H_BLANK - 1);
      if (pre_line && (cnt_q == blank_last || cnt_q == blank_last - CW'(2)))
         rd_en_d = 1'b1;
      if (state_q == LINE && bc_q[0] &&
          (32'(bc_q) + 32'd5 <= 32'(2 * H_ACTIVE)))
         rd_en_d = 1'b1;

      if (rd_en_d) begin
         rd_addr_d = addr_q;
         addr_d    = addr_q + 1'b1;
      end

      // Bus outputs registered from the next state so they change together.
      vsync_d = (state_d == VS_PRE) || (state_d == VS_POST);
      href_d  = (state_d == LINE);
      dvld_d  = rd_en_q;
      b1_d    = dvld_q ? exp_byte1(mem_rd_data) : b1_q;
      px_d    = 8'h00;
      if (href_d)
         px_d = dvld_q ? exp_byte0(mem_rd_data) : b1_q;
   end

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bc_q      <= '0;
         line_q    <= '0;
         addr_q    <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         dvld_q    <= 1'b0;
         b1_q      <= 8'h00;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         px_q      <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bc_q      <= bc_d;
         line_q    <= line_d;
         addr_q    <= addr_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         dvld_q    <= dvld_d;
         b1_q      <= b1_d;
         start_q   <= start;
         busy_q    <= busy_d;
         done_q    <= done_d;
         vsync_q   <= vsync_d;
         href_q    <= href_d;
         px_q      <= px_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_rd_addr = rd_addr_q;
   assign mem_rd_en   = rd_en_q;
   assign vsync       = vsync_q;
   assign href        = href_q;
   assign px_data     = px_q;

endmodule
